// File: rtl/ecdh_pkg.sv
// Shared types and constants for the ECDH scalar-multiplication controller.
package ecdh_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SCAN = 3'd1,
        NEXT = 3'd2,
        DBL  = 3'd3,
        CHK  = 3'd4,
        ADD  = 3'd5,
        DONE = 3'd6
    } state_e;

    localparam logic OP_DOUBLE = 1'b0;
    localparam logic OP_ADD    = 1'b1;

    localparam logic MODE_PA  = 1'b0;
    localparam logic MODE_PAB = 1'b1;

endpackage

// File: rtl/ecdh_result_bank.sv
// Two-slot result store (Pa / Pab) with sticky per-slot valid flags.
module ecdh_result_bank
    import ecdh_pkg::*;
#(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_en,
    input  logic             clr_mode,
    input  logic             wr_en,
    input  logic             wr_mode,
    input  logic [WIDTH-1:0] wr_x,
    input  logic [WIDTH-1:0] wr_y,
    input  logic             wr_inf,
    output logic [WIDTH-1:0] o_Pa_x,
    output logic [WIDTH-1:0] o_Pa_y,
    output logic             o_Pa_inf,
    output logic             o_pa_valid,
    output logic [WIDTH-1:0] o_Pab_x,
    output logic [WIDTH-1:0] o_Pab_y,
    output logic             o_Pab_inf,
    output logic             o_pab_valid
);

    logic [WIDTH-1:0] pa_x_q, pa_x_d, pa_y_q, pa_y_d;
    logic [WIDTH-1:0] pab_x_q, pab_x_d, pab_y_q, pab_y_d;
    logic             pa_inf_q, pa_inf_d, pa_valid_q, pa_valid_d;
    logic             pab_inf_q, pab_inf_d, pab_valid_q, pab_valid_d;

    always_comb begin
        pa_x_d      = pa_x_q;
        pa_y_d      = pa_y_q;
        pa_inf_d    = pa_inf_q;
        pa_valid_d  = pa_valid_q;
        pab_x_d     = pab_x_q;
        pab_y_d     = pab_y_q;
        pab_inf_d   = pab_inf_q;
        pab_valid_d = pab_valid_q;

        if (clr_en) begin
            if (clr_mode == MODE_PA) begin
                pa_valid_d = 1'b0;
            end else begin
                pab_valid_d = 1'b0;
            end
        end

        if (wr_en) begin
            if (wr_mode == MODE_PA) begin
                pa_x_d     = wr_x;
                pa_y_d     = wr_y;
                pa_inf_d   = wr_inf;
                pa_valid_d = 1'b1;
            end else begin
                pab_x_d     = wr_x;
                pab_y_d     = wr_y;
                pab_inf_d   = wr_inf;
                pab_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pa_x_q      <= '0;
            pa_y_q      <= '0;
            pa_inf_q    <= 1'b0;
            pa_valid_q  <= 1'b0;
            pab_x_q     <= '0;
            pab_y_q     <= '0;
            pab_inf_q   <= 1'b0;
            pab_valid_q <= 1'b0;
        end else begin
            pa_x_q      <= pa_x_d;
            pa_y_q      <= pa_y_d;
            pa_inf_q    <= pa_inf_d;
            pa_valid_q  <= pa_valid_d;
            pab_x_q     <= pab_x_d;
            pab_y_q     <= pab_y_d;
            pab_inf_q   <= pab_inf_d;
            pab_valid_q <= pab_valid_d;
        end
    end

    assign o_Pa_x      = pa_x_q;
    assign o_Pa_y      = pa_y_q;
    assign o_Pa_inf    = pa_inf_q;
    assign o_pa_valid  = pa_valid_q;
    assign o_Pab_x     = pab_x_q;
    assign o_Pab_y     = pab_y_q;
    assign o_Pab_inf   = pab_inf_q;
    assign o_pab_valid = pab_valid_q;

endmodule

// File: rtl/ecdh_scalar_mul_ctrl.sv
// MSB-first double-and-add sequencer for R = a*Q; point arithmetic is delegated
// to an external point-op unit over a req/done handshake.
module ecdh_scalar_mul_ctrl
    import ecdh_pkg::*;
#(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_P_x,
    input  logic [WIDTH-1:0] i_P_y,
    input  logic [WIDTH-1:0] i_Pb_x,
    input  logic [WIDTH-1:0] i_Pb_y,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_prime,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_Pa_x,
    output logic [WIDTH-1:0] o_Pa_y,
    output logic             o_Pa_inf,
    output logic             o_pa_valid,
    output logic [WIDTH-1:0] o_Pab_x,
    output logic [WIDTH-1:0] o_Pab_y,
    output logic             o_Pab_inf,
    output logic             o_pab_valid,
    output logic             o_op_req,
    output logic             o_op_kind,
    output logic [WIDTH-1:0] o_op_Ax,
    output logic [WIDTH-1:0] o_op_Ay,
    output logic [WIDTH-1:0] o_op_Bx,
    output logic [WIDTH-1:0] o_op_By,
    output logic [WIDTH-1:0] o_op_prime,
    input  logic             i_op_done,
    input  logic [WIDTH-1:0] i_op_Rx,
    input  logic [WIDTH-1:0] i_op_Ry,
    input  logic             i_op_Rinf
);

    typedef struct packed {
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic             inf;
    } point_t;

    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] q_x_q, q_x_d, q_y_q, q_y_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] prime_q, prime_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    point_t           acc_q, acc_d;
    logic             busy_q, busy_d;
    logic             op_req_q, op_req_d;
    logic             op_kind_q, op_kind_d;

    logic             bank_clr_en, bank_clr_mode, bank_wr_en;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        q_x_d         = q_x_q;
        q_y_d         = q_y_q;
        a_d           = a_q;
        prime_d       = prime_q;
        idx_d         = idx_q;
        acc_d         = acc_q;
        busy_d        = busy_q;
        op_req_d      = op_req_q;
        op_kind_d     = op_kind_q;
        bank_clr_en   = 1'b0;
        bank_clr_mode = MODE_PA;
        bank_wr_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_start && !busy_q) begin
                    mode_d        = i_mode;
                    q_x_d         = (i_mode == MODE_PAB) ? i_Pb_x : i_P_x;
                    q_y_d         = (i_mode == MODE_PAB) ? i_Pb_y : i_P_y;
                    a_d           = i_a;
                    prime_d       = i_prime;
                    idx_d         = IDX_TOP;
                    acc_d         = '{x: '0, y: '0, inf: 1'b1};
                    busy_d        = 1'b1;
                    bank_clr_en   = 1'b1;
                    bank_clr_mode = i_mode;
                    state_d       = SCAN;
                end
            end
            // Leading zeros cost one cycle each; the first set bit seeds acc with Q.
            SCAN: begin
                if (a_q[idx_q]) begin
                    acc_d   = '{x: q_x_q, y: q_y_q, inf: 1'b0};
                    state_d = NEXT;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            NEXT: begin
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d     = idx_q - IDX_ONE;
                    op_req_d  = !acc_q.inf;
                    op_kind_d = OP_DOUBLE;
                    state_d   = DBL;
                end
            end
            DBL: begin
                if (!op_req_q) begin
                    state_d = CHK;
                end else if (i_op_done) begin
                    acc_d    = '{x: i_op_Rx, y: i_op_Ry, inf: i_op_Rinf};
                    op_req_d = 1'b0;
                    state_d  = CHK;
                end
            end
            CHK: begin
                if (a_q[idx_q]) begin
                    op_req_d  = !acc_q.inf;
                    op_kind_d = OP_ADD;
                    state_d   = ADD;
                end else begin
                    state_d = NEXT;
                end
            end
            // inf + Q is just Q, so no request is issued from infinity.
            ADD: begin
                if (!op_req_q) begin
                    acc_d   = '{x: q_x_q, y: q_y_q, inf: 1'b0};
                    state_d = NEXT;
                end else if (i_op_done) begin
                    acc_d    = '{x: i_op_Rx, y: i_op_Ry, inf: i_op_Rinf};
                    op_req_d = 1'b0;
                    state_d  = NEXT;
                end
            end
            DONE: begin
                bank_wr_en = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d  = IDLE;
                busy_d   = 1'b0;
                op_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_PA;
            q_x_q     <= '0;
            q_y_q     <= '0;
            a_q       <= '0;
            prime_q   <= '0;
            idx_q     <= '0;
            acc_q     <= '{x: '0, y: '0, inf: 1'b1};
            busy_q    <= 1'b0;
            op_req_q  <= 1'b0;
            op_kind_q <= OP_DOUBLE;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            q_x_q     <= q_x_d;
            q_y_q     <= q_y_d;
            a_q       <= a_d;
            prime_q   <= prime_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            busy_q    <= busy_d;
            op_req_q  <= op_req_d;
            op_kind_q <= op_kind_d;
        end
    end

    ecdh_result_bank #(
        .WIDTH(WIDTH)
    ) u_result_bank (
        .clk        (clk),
        .rst        (rst),
        .clr_en     (bank_clr_en),
        .clr_mode   (bank_clr_mode),
        .wr_en      (bank_wr_en),
        .wr_mode    (mode_q),
        .wr_x       (acc_q.x),
        .wr_y       (acc_q.y),
        .wr_inf     (acc_q.inf),
        .o_Pa_x     (o_Pa_x),
        .o_Pa_y     (o_Pa_y),
        .o_Pa_inf   (o_Pa_inf),
        .o_pa_valid (o_pa_valid),
        .o_Pab_x    (o_Pab_x),
        .o_Pab_y    (o_Pab_y),
        .o_Pab_inf  (o_Pab_inf),
        .o_pab_valid(o_pab_valid)
    );

    assign o_busy     = busy_q;
    assign o_op_req   = op_req_q;
    assign o_op_kind  = op_kind_q;
    assign o_op_Ax    = acc_q.x;
    assign o_op_Ay    = acc_q.y;
    assign o_op_Bx    = q_x_q;
    assign o_op_By    = q_y_q;
    assign o_op_prime = prime_q;

endmodule

// File: tb/tb_ecdh_scalar_mul_ctrl.sv
// Bench for ecdh_scalar_mul_ctrl on y^2 = x^3 + 2x + 2 mod 17 (group order 19),
// with a behavioural point-op unit and a repeated-addition reference model.
module tb_ecdh_scalar_mul_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int PRIME = 17;
    localparam int ORDER = 19;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             i_start = 1'b0;
    logic             i_mode = 1'b0;
    logic [WIDTH-1:0] i_P_x = '0, i_P_y = '0, i_Pb_x = '0, i_Pb_y = '0;
    logic [WIDTH-1:0] i_a = '0, i_prime = '0;
    logic             o_busy;
    logic [WIDTH-1:0] o_Pa_x, o_Pa_y, o_Pab_x, o_Pab_y;
    logic             o_Pa_inf, o_pa_valid, o_Pab_inf, o_pab_valid;
    logic             o_op_req, o_op_kind;
    logic [WIDTH-1:0] o_op_Ax, o_op_Ay, o_op_Bx, o_op_By, o_op_prime;
    logic             i_op_done = 1'b0;
    logic [WIDTH-1:0] i_op_Rx = '0, i_op_Ry = '0;
    logic             i_op_Rinf = 1'b0;

    always #5 clk = ~clk;

    ecdh_scalar_mul_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_mode(i_mode),
        .i_P_x(i_P_x), .i_P_y(i_P_y), .i_Pb_x(i_Pb_x), .i_Pb_y(i_Pb_y),
        .i_a(i_a), .i_prime(i_prime), .o_busy(o_busy),
        .o_Pa_x(o_Pa_x), .o_Pa_y(o_Pa_y), .o_Pa_inf(o_Pa_inf), .o_pa_valid(o_pa_valid),
        .o_Pab_x(o_Pab_x), .o_Pab_y(o_Pab_y), .o_Pab_inf(o_Pab_inf), .o_pab_valid(o_pab_valid),
        .o_op_req(o_op_req), .o_op_kind(o_op_kind),
        .o_op_Ax(o_op_Ax), .o_op_Ay(o_op_Ay), .o_op_Bx(o_op_Bx), .o_op_By(o_op_By),
        .o_op_prime(o_op_prime), .i_op_done(i_op_done),
        .i_op_Rx(i_op_Rx), .i_op_Ry(i_op_Ry), .i_op_Rinf(i_op_Rinf)
    );

    typedef struct {
        int x;
        int y;
        bit inf;
    } pt_t;

    typedef struct {
        int x;
        int y;
        bit inf;
        bit v;
    } slot_t;

    typedef struct {
        bit  mode;
        int  a;
        int  qx;
        int  qy;
        int  dly;
        bit  poke;
        bit  einf;
        int  ex;
        int  ey;
        int  en;
        int  ep;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    int    op_delay = 0;
    int    op_errs = 0;
    bit    kinds[$];
    slot_t slots[2];

    function automatic int md(input int v);
        return ((v % PRIME) + PRIME) % PRIME;
    endfunction

    function automatic int inv(input int v);
        int r = 1;
        for (int i = 0; i < PRIME - 2; i++) r = md(r * v);
        return r;
    endfunction

    function automatic pt_t pt_add(input pt_t a, input pt_t b);
        pt_t r;
        int  lam;
        if (a.inf) return b;
        if (b.inf) return a;
        r.inf = 1'b0;
        if (a.x == b.x) begin
            if (md(a.y + b.y) == 0) begin
                r.inf = 1'b1; r.x = 0; r.y = 0;
                return r;
            end
            lam = md(md(3 * a.x * a.x + 2) * inv(md(2 * a.y)));
        end else begin
            lam = md(md(b.y - a.y) * inv(md(b.x - a.x)));
        end
        r.x = md(lam * lam - a.x - b.x);
        r.y = md(lam * (a.x - r.x) - a.y);
        return r;
    endfunction

    function automatic pt_t smul(input int k, input pt_t q);
        pt_t r = '{0, 0, 1'b1};
        for (int i = 0; i < k; i++) r = pt_add(r, q);
        return r;
    endfunction

    // Request sequence implied by the scan rules: k tracks acc as a multiple of Q.
    function automatic void exp_ops(input int a, output int n, output int pat);
        int k = 0;
        bit started = 1'b0;
        n = 0; pat = 0;
        for (int b = WIDTH - 1; b >= 0; b--) begin
            if (!started) begin
                if (a[b]) begin started = 1'b1; k = 1; end
            end else begin
                if (k != 0) begin n++; pat = pat << 1; end
                k = (2 * k) % ORDER;
                if (a[b]) begin
                    if (k != 0) begin n++; pat = (pat << 1) | 1; end
                    k = (k + 1) % ORDER;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic verify_slots(input string tag);
        chk($sformatf("%s pa_valid", tag), int'(o_pa_valid), int'(slots[0].v));
        chk($sformatf("%s pab_valid", tag), int'(o_pab_valid), int'(slots[1].v));
        if (slots[0].v) begin
            chk($sformatf("%s pa_inf", tag), int'(o_Pa_inf), int'(slots[0].inf));
            if (!slots[0].inf) begin
                chk($sformatf("%s pa_x", tag), int'(o_Pa_x), slots[0].x);
                chk($sformatf("%s pa_y", tag), int'(o_Pa_y), slots[0].y);
            end
        end
        if (slots[1].v) begin
            chk($sformatf("%s pab_inf", tag), int'(o_Pab_inf), int'(slots[1].inf));
            if (!slots[1].inf) begin
                chk($sformatf("%s pab_x", tag), int'(o_Pab_x), slots[1].x);
                chk($sformatf("%s pab_y", tag), int'(o_Pab_y), slots[1].y);
            end
        end
    endtask

    // Behavioural point-op unit with programmable done delay.
    initial begin : op_unit
        pt_t a, b, r;
        int  ax, ay, bx, by;
        bit  kind;
        forever begin
            @(negedge clk);
            if (o_op_req && !rst) begin
                kind = o_op_kind;
                ax = int'(o_op_Ax); ay = int'(o_op_Ay);
                bx = int'(o_op_Bx); by = int'(o_op_By);
                kinds.push_back(kind);
                if (int'(o_op_prime) != PRIME) op_errs++;
                a = '{ax, ay, 1'b0};
                b = kind ? '{bx, by, 1'b0} : a;
                r = pt_add(a, b);
                for (int i = 0; i < op_delay; i++) begin
                    @(negedge clk);
                    if (o_op_req && (int'(o_op_Ax) != ax || int'(o_op_Ay) != ay ||
                                     int'(o_op_Bx) != bx || int'(o_op_By) != by ||
                                     o_op_kind != kind)) op_errs++;
                end
                i_op_done = 1'b1;
                i_op_Rx   = WIDTH'(r.x);
                i_op_Ry   = WIDTH'(r.y);
                i_op_Rinf = r.inf;
                @(negedge clk);
                i_op_done = 1'b0;
                i_op_Rx   = WIDTH'($urandom);
                i_op_Ry   = WIDTH'($urandom);
                i_op_Rinf = 1'($urandom);
            end
        end
    end

    task automatic run_job(input string tag, input bit mode, input int a, input pt_t q,
                           input int dly, input bit poke, input pt_t er,
                           input int en, input int ep);
        int base, ncyc, pat;
        @(negedge clk);
        op_delay = dly;
        i_mode   = mode;
        i_a      = WIDTH'(a);
        if (mode) begin
            i_Pb_x = WIDTH'(q.x); i_Pb_y = WIDTH'(q.y);
            i_P_x  = WIDTH'($urandom); i_P_y = WIDTH'($urandom);
        end else begin
            i_P_x  = WIDTH'(q.x); i_P_y = WIDTH'(q.y);
            i_Pb_x = WIDTH'($urandom); i_Pb_y = WIDTH'($urandom);
        end
        i_prime = WIDTH'(PRIME);
        i_start = 1'b1;
        base    = kinds.size();
        @(negedge clk);
        i_start = 1'b0;
        i_a     = WIDTH'($urandom);
        i_P_x   = WIDTH'($urandom); i_P_y  = WIDTH'($urandom);
        i_Pb_x  = WIDTH'($urandom); i_Pb_y = WIDTH'($urandom);
        i_prime = WIDTH'($urandom);
        ncyc = 1;
        chk($sformatf("%s busy_after_start", tag), int'(o_busy), 1);
        chk($sformatf("%s valid_cleared", tag), int'(mode ? o_pab_valid : o_pa_valid), 0);
        while (o_busy && ncyc < 3000) begin
            i_start = poke && (ncyc == 3);
            i_mode  = ~mode;
            @(negedge clk);
            ncyc++;
        end
        i_start = 1'b0;
        chk($sformatf("%s finished", tag), int'(o_busy), 0);
        chk($sformatf("%s op_count", tag), kinds.size() - base, en);
        pat = 0;
        for (int i = base; i < kinds.size(); i++) pat = (pat << 1) | int'(kinds[i]);
        chk($sformatf("%s op_kinds", tag), pat, ep);
        if (a == 0) chk($sformatf("%s zero_latency_ok", tag), int'(ncyc <= WIDTH + 2), 1);
        slots[mode] = '{er.x, er.y, er.inf, 1'b1};
        verify_slots(tag);
    endtask

    vec_t tbl[6];
    pt_t  p_base, q, er;
    int   base, cyc, n, pat, k, a;
    bit   mode;

    initial begin
        p_base = '{5, 1, 1'b0};
        tbl[0] = '{1'b0,  1, 5, 1, 1, 1'b0, 1'b0, 5, 1, 0, 0};
        tbl[1] = '{1'b0,  9, 5, 1, 2, 1'b0, 1'b0, 7, 6, 4, 1};
        tbl[2] = '{1'b1,  2, 6, 3, 0, 1'b0, 1'b0, 3, 1, 1, 0};
        tbl[3] = '{1'b0,  0, 5, 1, 0, 1'b0, 1'b1, 0, 0, 0, 0};
        tbl[4] = '{1'b0, 19, 5, 1, 0, 1'b1, 1'b1, 0, 0, 6, 5};
        tbl[5] = '{1'b0, 19, 5, 1, 7, 1'b0, 1'b1, 0, 0, 6, 5};
        slots[0] = '{0, 0, 1'b0, 1'b0};
        slots[1] = '{0, 0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset busy", int'(o_busy), 0);
        chk("reset op_req", int'(o_op_req), 0);
        chk("reset pa_valid", int'(o_pa_valid), 0);
        chk("reset pab_valid", int'(o_pab_valid), 0);
        chk("reset pa_inf", int'(o_Pa_inf), 0);
        chk("reset op_prime", int'(o_op_prime), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_job($sformatf("vec%0d", i), tbl[i].mode, tbl[i].a,
                    '{tbl[i].qx, tbl[i].qy, 1'b0}, tbl[i].dly, tbl[i].poke,
                    '{tbl[i].ex, tbl[i].ey, tbl[i].einf}, tbl[i].en, tbl[i].ep);
        end

        // Reset during the second request of a=9, then a late done pulse.
        @(negedge clk);
        op_delay = 7;
        i_mode = 1'b0; i_a = WIDTH'(9); i_P_x = WIDTH'(5); i_P_y = WIDTH'(1);
        i_prime = WIDTH'(PRIME); i_start = 1'b1;
        base = kinds.size();
        @(negedge clk);
        i_start = 1'b0;
        cyc = 0;
        while (kinds.size() - base < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst second_req_seen", kinds.size() - base, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("rst op_req", int'(o_op_req), 0);
        chk("rst pa_valid", int'(o_pa_valid), 0);
        chk("rst pab_valid", int'(o_pab_valid), 0);
        chk("rst busy", int'(o_busy), 0);
        rst = 1'b0;
        slots[0] = '{0, 0, 1'b0, 1'b0};
        slots[1] = '{0, 0, 1'b0, 1'b0};
        repeat (12) @(negedge clk);
        chk("late_done op_req", int'(o_op_req), 0);
        chk("late_done busy", int'(o_busy), 0);
        chk("late_done no_new_req", kinds.size() - base, 2);
        verify_slots("late_done");
        run_job("after_rst", 1'b0, 2, p_base, 1, 1'b0, '{6, 3, 1'b0}, 1, 0);

        for (int j = 0; j < 24; j++) begin
            mode = 1'($urandom_range(0, 1));
            k    = int'($urandom_range(1, ORDER - 1));
            q    = smul(k, p_base);
            a    = int'($urandom_range(0, 255));
            er   = smul(a % ORDER, q);
            exp_ops(a, n, pat);
            run_job($sformatf("rnd%0d_a%0d_m%0d", j, a, mode), mode, a, q,
                    int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), er, n, pat);
        end

        chk("op_operands_stable", op_errs, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
